// File: rtl/booth_seq_pkg.sv
// ============================================================================
// Module   : booth_seq_pkg
// Brief    : Shared state encoding and default sizing for the Booth sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_seq_pkg;

    localparam int c_DEF_CNT_W = 4;
    localparam int c_DEF_LAST  = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/booth_sequencer_decode.sv
// ============================================================================
// Module   : booth_decode
// Brief    : Radix-2 Booth recoder: {q0,q_m1} -> add/sub strobes when enabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_decode (
    input  logic i_en,
    input  logic i_q0,
    input  logic i_q_m1,
    output logic o_add,
    output logic o_sub
);

    // 01 marks the end of a run of ones (add), 10 the start of one (subtract)
    assign o_add = i_en & ~i_q0 &  i_q_m1;
    assign o_sub = i_en &  i_q0 & ~i_q_m1;

endmodule

`default_nettype wire

// File: rtl/booth_sequencer.sv
// ============================================================================
// Module   : booth_sequencer
// Brief    : Control FSM for a 16-bit radix-2 Booth multiplier with an external
//            iteration counter. Optional abort input under BOOTH_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_sequencer
    import booth_seq_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int LAST  = c_DEF_LAST
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             q0,
    input  logic             q_m1,
`ifdef BOOTH_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             c_up,
    output logic             cnt_clr,
    output logic             ld_a,
    output logic             ld_q,
    output logic             add,
    output logic             sub,
    output logic             shift,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_LAST_V = CNT_W'(LAST);

    state_t r_state;
    logic   w_abort;
    logic   w_test;

`ifdef BOOTH_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else if (w_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= start ? S_LOAD : S_IDLE;
                S_LOAD:  r_state <= S_TEST;
                S_TEST:  r_state <= S_SHIFT;
                // cnt_in is the pre-increment value; the counter wraps to 0 on this c_up
                S_SHIFT: r_state <= (cnt_in == c_LAST_V) ? S_DONE : S_TEST;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes come purely from the state register; an abort suppresses them
    // in the cycle it is asserted so nothing reaches the datapath or counter.
    always_comb begin
        ld_a    = 1'b0;
        ld_q    = 1'b0;
        cnt_clr = 1'b0;
        shift   = 1'b0;
        c_up    = 1'b0;
        done    = 1'b0;
        busy    = (r_state != S_IDLE);
        if (!w_abort) begin
            case (r_state)
                S_LOAD: begin
                    ld_a    = 1'b1;
                    ld_q    = 1'b1;
                    cnt_clr = 1'b1;
                end
                S_SHIFT: begin
                    shift = 1'b1;
                    c_up  = 1'b1;
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_test = (r_state == S_TEST) & ~w_abort;

    booth_decode u_decode (
        .i_en   (w_test),
        .i_q0   (q0),
        .i_q_m1 (q_m1),
        .o_add  (add),
        .o_sub  (sub)
    );

endmodule

`default_nettype wire

// File: tb/tb_booth_sequencer.sv
// ============================================================================
// Module   : tb_booth_sequencer
// Brief    : Self-checking bench for booth_sequencer with counter and datapath
//            models. Exercises abort when BOOTH_SEQ_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_sequencer;

    logic        clk = 1'b0;
    logic        rst_b, start, q0, q_m1;
    logic [3:0]  cnt_in;
    logic        c_up, cnt_clr, ld_a, ld_q, add, sub, shift, busy, done;
`ifdef BOOTH_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    always #5 clk = ~clk;

    booth_sequencer #(.CNT_W(4), .LAST(15)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .cnt_in  (cnt_in),
        .q0      (q0),
        .q_m1    (q_m1),
`ifdef BOOTH_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .c_up    (c_up),
        .cnt_clr (cnt_clr),
        .ld_a    (ld_a),
        .ld_q    (ld_q),
        .add     (add),
        .sub     (sub),
        .shift   (shift),
        .busy    (busy),
        .done    (done)
    );

    logic [8:0] w_outs;
    assign w_outs = {c_up, cnt_clr, ld_a, ld_q, add, sub, shift, busy, done};

    // Counter model: clear, increment, wrap; cnt_in may be overridden
    logic [3:0] r_cnt;
    logic       force_en = 1'b0;
    always @(posedge clk) begin
        if (!rst_b)       r_cnt <= 4'd0;
        else if (cnt_clr) r_cnt <= 4'd0;
        else if (c_up)    r_cnt <= r_cnt + 4'd1;
    end
    assign cnt_in = force_en ? 4'd15 : r_cnt;

    // Datapath model: A:Q:Q[-1] driven by the sequencer strobes
    logic        dp_mode = 1'b0;
    logic [1:0]  fixed_q = 2'b00;
    logic [15:0] mcand = 16'd0, mplier = 16'd0;
    logic [15:0] r_a = 16'd0, r_q = 16'd0;
    logic        r_qm1 = 1'b0;
    always @(posedge clk) begin
        if (ld_a) r_a <= 16'd0;
        if (ld_q) begin
            r_q   <= mplier;
            r_qm1 <= 1'b0;
        end
        if (add)      r_a <= r_a + mcand;
        else if (sub) r_a <= r_a - mcand;
        if (shift) {r_a, r_q, r_qm1} <= {r_a[15], r_a, r_q};
    end
    assign q0   = dp_mode ? r_q[0] : fixed_q[1];
    assign q_m1 = dp_mode ? r_qm1  : fixed_q[0];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] prod;
        bit          chk;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          dp;
        logic [1:0]  fq;
        logic [15:0] mc;
        logic [15:0] mp;
        int          pa;
        int          pb;
        int          fc;
        int          e_add;
        int          e_sub;
        int          e_shift;
        int          e_done;
        logic [31:0] e_prod;
    } vec_t;
    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n_add = 0, n_sub = 0, n_both = 0, n_shift = 0, n_cup = 0;
        int   n_ld = 0, ld_cyc = -1, n_busy = 0, n_done = 0;
        exp_t e;
        string p;
        p = $sformatf("v%0d", idx);
        dp_mode = v.dp;
        fixed_q = v.fq;
        mcand   = v.mc;
        mplier  = v.mp;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back('{cyc: v.e_done, prod: v.e_prod, chk: v.dp});
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            force_en = (cyc == v.fc);
            #1;
            if (ld_a && ld_q && cnt_clr) begin
                n_ld++;
                ld_cyc = cyc;
            end
            if (add)         n_add++;
            if (sub)         n_sub++;
            if (add && sub)  n_both++;
            if (shift)       n_shift++;
            if (c_up)        n_cup++;
            if (busy)        n_busy++;
            if (done) begin
                n_done++;
                check({p, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check({p, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                    if (e.chk) check({p, "_product"}, {r_a, r_q}, e.prod);
                end
            end
            start = (cyc == v.pa) || (cyc == v.pb);
            step();
        end
        force_en = 1'b0;
        start    = 1'b0;
        check({p, "_ld_cycle"},  32'(ld_cyc),  32'd1);
        check({p, "_ld_count"},  32'(n_ld),    32'd1);
        check({p, "_add_count"}, 32'(n_add),   32'(v.e_add));
        check({p, "_sub_count"}, 32'(n_sub),   32'(v.e_sub));
        check({p, "_add_and_sub"}, 32'(n_both), 32'd0);
        check({p, "_shift_count"}, 32'(n_shift), 32'(v.e_shift));
        check({p, "_cup_count"}, 32'(n_cup),   32'(v.e_shift));
        check({p, "_busy_cycles"}, 32'(n_busy), 32'(v.e_done));
        check({p, "_done_count"}, 32'(n_done), 32'd1);
        check({p, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int n_done;

        vecs[0] = '{dp:1'b0, fq:2'b00, mc:16'd0, mp:16'd0, pa:-1, pb:-1, fc:-1,
                    e_add:0,  e_sub:0,  e_shift:16, e_done:34, e_prod:32'd0};
        vecs[1] = '{dp:1'b0, fq:2'b01, mc:16'd0, mp:16'd0, pa:-1, pb:-1, fc:-1,
                    e_add:16, e_sub:0,  e_shift:16, e_done:34, e_prod:32'd0};
        vecs[2] = '{dp:1'b0, fq:2'b10, mc:16'd0, mp:16'd0, pa:-1, pb:-1, fc:-1,
                    e_add:0,  e_sub:16, e_shift:16, e_done:34, e_prod:32'd0};
        vecs[3] = '{dp:1'b0, fq:2'b11, mc:16'd0, mp:16'd0, pa:-1, pb:-1, fc:-1,
                    e_add:0,  e_sub:0,  e_shift:16, e_done:34, e_prod:32'd0};
        vecs[4] = '{dp:1'b1, fq:2'b00, mc:16'd7, mp:16'hFFFD, pa:-1, pb:-1, fc:-1,
                    e_add:1,  e_sub:2,  e_shift:16, e_done:34, e_prod:32'hFFFF_FFEB};
        vecs[5] = '{dp:1'b0, fq:2'b00, mc:16'd0, mp:16'd0, pa:5, pb:34, fc:-1,
                    e_add:0,  e_sub:0,  e_shift:16, e_done:34, e_prod:32'd0};
        vecs[6] = '{dp:1'b1, fq:2'b00, mc:16'd3, mp:16'd5, pa:-1, pb:-1, fc:-1,
                    e_add:2,  e_sub:2,  e_shift:16, e_done:34, e_prod:32'h0000_000F};
        vecs[7] = '{dp:1'b0, fq:2'b00, mc:16'd0, mp:16'd0, pa:-1, pb:-1, fc:3,
                    e_add:0,  e_sub:0,  e_shift:1,  e_done:4,  e_prod:32'd0};

        rst_b = 1'b0;
        start = 1'b1;
        repeat (3) step();
        check("reset_outputs", {23'd0, w_outs}, 32'd0);
        start = 1'b0;
        rst_b = 1'b1;
        step();
        check("idle_outputs", {23'd0, w_outs}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an operation
        dp_mode = 1'b0;
        fixed_q = 2'b00;
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("midrun_busy_c10", {31'd0, busy}, 32'd1);
        rst_b = 1'b0;
        step();
        check("midrun_reset_outputs", {23'd0, w_outs}, 32'd0);
        rst_b = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) n_done++;
            step();
        end
        check("midrun_reset_stays_idle", 32'(n_done), 32'd0);

`ifdef BOOTH_SEQ_ABORT_EN
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        check("abort_busy_c12", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle_c13", {23'd0, w_outs}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) n_done++;
            step();
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_blocks_start", {31'd0, busy}, 32'd0);
        run_vec(8, vecs[0]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of the iteration count returned by the external counter.
REQ-002 Parameter LAST, default 15: count value at which the final iteration is issued.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a 16-bit radix-2 Booth multiply; sampled only in IDLE.
REQ-006 cnt_in  input  CNT_W  iteration count from the downstream counter's out port.
REQ-007 q0  input  1  LSB of the datapath Q register.
REQ-008 q_m1  input  1  Booth extra bit (Q[-1]).
REQ-009 c_up  output  1  increment strobe to the counter.
REQ-010 cnt_clr  output  1  counter clear strobe.
REQ-011 ld_a, ld_q  output  1 each  load accumulator (clear) and load multiplier.
REQ-012 add, sub  output  1 each  accumulator add/subtract multiplicand strobes.
REQ-013 shift  output  1  arithmetic right shift of the A:Q:Q[-1] register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 States: IDLE, LOAD, TEST, SHIFT, DONE.
REQ-017 IDLE: all strobes 0; start=1 -> LOAD, otherwise stay.
REQ-018 LOAD: ld_a=ld_q=cnt_clr=1 for exactly one cycle -> TEST.
REQ-019 TEST: {q0,q_m1}=01 -> add=1; 10 -> sub=1; 00/11 -> neither; add and sub never both 1; always -> SHIFT.
REQ-020 SHIFT: shift=1 and c_up=1 in the same cycle; cnt_in==LAST (value before the increment) -> DONE, otherwise -> TEST.
REQ-021 DONE: done=1 for one cycle, busy=1 -> IDLE; start in DONE is ignored.
REQ-022 start while busy is ignored, with no queuing.
REQ-023 Latency: start sampled at edge 0 -> LOAD in cycle 1, 16 TEST/SHIFT pairs in cycles 2-33, done in cycle 34.
REQ-024 Counter wrap from LAST to 0 on the final c_up is expected and is not an error.
REQ-025 The sequencer trusts cnt_in; an early cnt_in==LAST ends the operation at that SHIFT.
REQ-026 Outputs other than add/sub are decoded from state only; add/sub are decoded from state plus {q0,q_m1}.

Reset
REQ-027 rst_b=0 at a rising edge forces IDLE in any state, including mid-operation.
REQ-028 After reset all outputs are 0: c_up, cnt_clr, ld_a, ld_q, add, sub, shift, busy, done.
REQ-029 Reset does not drive cnt_clr; the counter's own reset clears it.

Configuration
REQ-030 Macro BOOTH_SEQ_ABORT_EN defined: add input port abort (1 bit).
REQ-031 With the macro, abort=1 in LOAD/TEST/SHIFT/DONE forces IDLE at the next edge, and all strobes, including done, are 0 in that cycle.
REQ-032 With the macro, abort=1 in IDLE blocks start, and abort has priority over start.
REQ-033 Macro undefined: no abort port, and behaviour is exactly REQ-016 to REQ-029.

Structure
REQ-034 Shared package booth_seq_pkg holds the state encoding typedef (3-bit) and the default LAST/CNT_W constants.
REQ-035 One sub-module, booth_decode, is natural: it maps {q0,q_m1} to add/sub.
REQ-036 The iteration counter stays external; no internal counter is allowed.

Verification
REQ-037 Drive start=1 with q0=0, q_m1=0 and a counter model -> ld_a/ld_q/cnt_clr in cycle 1, no add/sub, 16 shift and 16 c_up pulses, done in cycle 34, then busy=0.
REQ-038 Hold {q0,q_m1}=01 -> add=1 in all 16 TEST cycles; hold 10 -> sub=1 in all 16; add and sub never both high.
REQ-039 Run multiplicand 7 x multiplier -3 with the datapath model -> product 0xFFFF_FFEB at done.
REQ-040 Pulse start in cycles 5 and 34 -> ignored, and exactly one done pulse occurs.
REQ-041 Force cnt_in=15 at the first SHIFT -> DONE in cycle 4; then drive rst_b=0 in cycle 10 of a new run -> IDLE, all outputs 0 next cycle.
REQ-042 With BOOTH_SEQ_ABORT_EN, abort in cycle 12 -> IDLE in cycle 13, no done pulse; a new start then gives done 34 cycles later.
